// File: rtl/maggie_ram_sched_if.sv
// Bus bundle between the MAGGIE RAM scheduler, the MAGGIE layer requesters,
// the external RAM and the host read port.
// The master modport is the scheduler's view of the bundle. The slave modport
// is the view of the requesters, the RAM and the host.
interface maggie_ram_sched_if #(
  parameter int LAYERS = 4
);
  logic [3:0]           pc_ena_out;
  logic [LAYERS-1:0]    layer_en;
  logic [LAYERS*20-1:0] layer_addr;
  logic [LAYERS*16-1:0] layer_rdata;
  logic [LAYERS-1:0]    layer_rvalid;
  logic [19:0]          ram_addr;
  logic                 ram_rd;
  logic [15:0]          ram_din;
  logic                 host_req;
  logic [19:0]          host_addr;
  logic                 host_ack;
  logic [15:0]          host_rdata;
  logic                 host_rvalid;

  modport master (
    output pc_ena_out,
    input  layer_en,
    input  layer_addr,
    output layer_rdata,
    output layer_rvalid,
    output ram_addr,
    output ram_rd,
    input  ram_din,
    input  host_req,
    input  host_addr,
    output host_ack,
    output host_rdata,
    output host_rvalid
  );

  modport slave (
    input  pc_ena_out,
    output layer_en,
    output layer_addr,
    input  layer_rdata,
    input  layer_rvalid,
    input  ram_addr,
    input  ram_rd,
    output ram_din,
    output host_req,
    output host_addr,
    input  host_ack,
    input  host_rdata,
    input  host_rvalid
  );
endinterface

// File: rtl/maggie_ram_sched.sv
// MAGGIE RAM scheduler: a free-running 16-slot TDM arbiter over one read port.
// Slots 0..LAYERS-1 belong to the layers. The remaining slots, and the slots
// of disabled layers, are free for the host. Every read carries a
// {valid, source} tag down a RAM_READ_CYCLES-deep pipeline. The tag routes
// the returned ram_din to the destination that requested it.
// Optional feature: define MAGGIE_SCHED_HOST_PORT_EN to build the host read
// port. Without it, the host outputs are tied to 0 and host slots stay idle.
module maggie_ram_sched #(
  parameter int LAYERS          = 4,
  parameter int RAM_READ_CYCLES = 3
) (
  input logic                clk,
  input logic                reset_n,
  maggie_ram_sched_if.master bus
);

  // Source id for host reads. LAYERS <= 15 keeps this id apart from every
  // layer id.
  localparam logic [3:0] HOST_ID = 4'hF;

  logic [3:0]           slot_q, slot_d, nxt_slot;
  logic [19:0]          ram_addr_q, ram_addr_d;
  logic                 ram_rd_q, ram_rd_d;
  logic [3:0]           src_q, src_d;
  logic                 tag_vld_q [RAM_READ_CYCLES];
  logic [3:0]           tag_id_q  [RAM_READ_CYCLES];
  logic                 exit_vld;
  logic [3:0]           exit_id;
  logic [LAYERS*16-1:0] layer_rdata_q, layer_rdata_d;
  logic [LAYERS-1:0]    layer_rvalid_q, layer_rvalid_d;

  logic                 lay_hit, lay_on;
  logic [19:0]          lay_addr;
  logic                 host_issue;
  logic [19:0]          host_iss_addr;

  assign nxt_slot = slot_q + 4'd1;
  assign slot_d   = nxt_slot;
  assign exit_vld = tag_vld_q[RAM_READ_CYCLES-1];
  assign exit_id  = tag_id_q[RAM_READ_CYCLES-1];

  // Decode the owner of the slot that starts at the next edge.
  always_comb begin
    lay_hit  = 1'b0;
    lay_on   = 1'b0;
    lay_addr = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (nxt_slot == 4'(i)) begin
        lay_hit  = 1'b1;
        lay_on   = bus.layer_en[i];
        lay_addr = bus.layer_addr[20*i +: 20];
      end
    end
  end

`ifdef MAGGIE_SCHED_HOST_PORT_EN
  // A host request passes through IDLE, then PEND, then ACK. The ACK state is
  // the slot in which the read is issued. Captures are blocked in PEND and in
  // ACK, so a new request is taken only from the cycle after the ack.
  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_PEND = 2'd1,
    H_ACK  = 2'd2
  } host_st_e;

  host_st_e    host_q, host_d;
  logic [19:0] haddr_q, haddr_d;
  logic        host_elig;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        host_rvalid_q, host_rvalid_d;

  assign host_elig     = ~(lay_hit & lay_on);
  assign host_issue    = (host_q == H_PEND) && host_elig;
  assign host_iss_addr = haddr_q;

  // Host request state and the captured address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      host_q  <= H_IDLE;
      haddr_q <= '0;
    end else begin
      host_q  <= host_d;
      haddr_q <= haddr_d;
    end
  end

  // Host next state. The request is pending for at least one full cycle, so
  // a captured request is never issued in the slot directly after capture.
  always_comb begin
    host_d  = host_q;
    haddr_d = haddr_q;
    case (host_q)
      H_IDLE: begin
        if (bus.host_req) begin
          host_d  = H_PEND;
          haddr_d = bus.host_addr;
        end
      end
      H_PEND:  if (host_elig) host_d = H_ACK;
      H_ACK:   host_d = H_IDLE;
      default: host_d = H_IDLE;
    endcase
  end

  // Host data return, selected by the exiting tag.
  always_comb begin
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    if (exit_vld && (exit_id == HOST_ID)) begin
      host_rdata_d  = bus.ram_din;
      host_rvalid_d = 1'b1;
    end
  end

  // Host return registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign bus.host_ack    = (host_q == H_ACK);
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
`else
  logic unused_host;

  assign unused_host     = ^{bus.host_req, bus.host_addr};
  assign host_issue      = 1'b0;
  assign host_iss_addr   = '0;
  assign bus.host_ack    = 1'b0;
  assign bus.host_rdata  = '0;
  assign bus.host_rvalid = 1'b0;
`endif

  // Request mux for the next slot. An enabled layer wins its own slot.
  // Otherwise a pending host read takes the slot. ram_addr holds when idle.
  always_comb begin
    ram_rd_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    src_d      = '0;
    if (lay_hit && lay_on) begin
      ram_rd_d   = 1'b1;
      ram_addr_d = lay_addr;
      src_d      = nxt_slot;
    end else if (host_issue) begin
      ram_rd_d   = 1'b1;
      ram_addr_d = host_iss_addr;
      src_d      = HOST_ID;
    end
  end

  // Slot counter and registered RAM request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q     <= '0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      src_q      <= '0;
    end else begin
      slot_q     <= slot_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      src_q      <= src_d;
    end
  end

  // Tag pipeline: one stage per RAM read cycle, fed from the ram_rd cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < RAM_READ_CYCLES; k++) begin
        tag_vld_q[k] <= 1'b0;
        tag_id_q[k]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= ram_rd_q;
      tag_id_q[0]  <= src_q;
      for (int k = 1; k < RAM_READ_CYCLES; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // Layer data return: only the tagged layer updates and pulses rvalid.
  always_comb begin
    layer_rdata_d  = layer_rdata_q;
    layer_rvalid_d = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (exit_vld && (exit_id == 4'(i))) begin
        layer_rdata_d[16*i +: 16] = bus.ram_din;
        layer_rvalid_d[i]         = 1'b1;
      end
    end
  end

  // Layer return registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      layer_rdata_q  <= '0;
      layer_rvalid_q <= '0;
    end else begin
      layer_rdata_q  <= layer_rdata_d;
      layer_rvalid_q <= layer_rvalid_d;
    end
  end

  assign bus.pc_ena_out   = slot_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_rd       = ram_rd_q;
  assign bus.layer_rdata  = layer_rdata_q;
  assign bus.layer_rvalid = layer_rvalid_q;

endmodule
